conf_bus_sched: RTL and testbench

//  Owns the shared config bus (data/addr/en) feeding ref_gen, pred, ocd_lvl, interrupter.

---
 rtl/conf_bus_sched.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_conf_bus_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_bus_sched.sv
// conf_bus_sched - owner of the shared config bus (data/addr/en).
//
// Drives the bus read by ref_gen, pred, ocd_lvl and the interrupter. After reset
// it loads the power-on presets into addresses 0..4, then forwards UART parameter
// writes through a one-deep pending buffer. When ocd_trip rises TRIP_MAX times
// inside one WINDOW_CYC window, it latches fault and forces PW to 0.
//
// Optional feature: define CONF_SOFTSTART_EN to ramp UART PW increases by +1
// every RAMP_CYC cycles (RAMP state, busy high) instead of writing them directly.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   uart_data/addr/rdy     UART parameter write (rdy is a 1-cycle strobe)
//   ocd_trip               OCD event level, synchronous to clk
//   fault_clr              1-cycle strobe, clears the latched fault
//   data/addr/en           config bus; en is a 1-cycle write strobe
//   busy                   high during preset load (and ramp)
//   fault                  latched OCD fault
//   ovf                    1-cycle pulse when a pending UART write is overwritten
module conf_bus_sched #(
    parameter int unsigned WINDOW_CYC = 500000,
    parameter int unsigned TRIP_MAX   = 4
`ifdef CONF_SOFTSTART_EN
    ,
    parameter int unsigned RAMP_CYC   = 50000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_data,
    input  logic [2:0] uart_addr,
    input  logic       uart_rdy,
    input  logic       ocd_trip,
    input  logic       fault_clr,
    output logic [7:0] data,
    output logic [2:0] addr,
    output logic       en,
    output logic       busy,
    output logic       fault,
    output logic       ovf
);

    localparam logic [2:0] ADDR_MAX     = 3'd4;
    localparam logic [2:0] REF_GEN_ADDR = 3'd0;
    localparam logic [2:0] PRED_ADDR    = 3'd1;
    localparam logic [2:0] OCD_ADDR     = 3'd2;
    localparam logic [2:0] FREQ_ADDR    = 3'd3;
    localparam logic [2:0] PW_ADDR      = 3'd4;
    localparam logic [2:0] INIT_DONE    = ADDR_MAX + 3'd1;

    localparam logic [7:0] PRESET_REF   = 8'd127;
    localparam logic [7:0] PRESET_PRED  = 8'd30;
    localparam logic [7:0] PRESET_OCD   = 8'd87;
    localparam logic [7:0] PRESET_FREQ  = 8'd10;
    localparam logic [7:0] PRESET_PW    = 8'd1;

    localparam int unsigned WIN_W  = (WINDOW_CYC > 2) ? $clog2(WINDOW_CYC) : 1;
    localparam int unsigned TRIP_W = $clog2(TRIP_MAX + 1);
`ifdef CONF_SOFTSTART_EN
    localparam int unsigned RC_W   = (RAMP_CYC > 2) ? $clog2(RAMP_CYC) : 1;
`endif

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_FWD,
        S_FLT
`ifdef CONF_SOFTSTART_EN
        ,
        S_RAMP
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          data_q, data_d;
    logic [2:0]          addr_q, addr_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic                ovf_q, ovf_d;
    logic [2:0]          idx_q, idx_d;
    logic                pend_vld_q, pend_vld_d;
    logic [2:0]          pend_addr_q, pend_addr_d;
    logic [7:0]          pend_data_q, pend_data_d;
    logic                ocd_prev_q;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [TRIP_W-1:0]   trip_q, trip_d;
`ifdef CONF_SOFTSTART_EN
    logic [7:0]          cur_pw_q, cur_pw_d;
    logic [7:0]          ramp_tgt_q, ramp_tgt_d;
    logic [RC_W-1:0]     ramp_cnt_q, ramp_cnt_d;
`endif

    logic trip_rise;
    logic trip_reach;
    logic win_wrap;
    logic uart_ok;
    logic pend_take;

    function automatic logic [7:0] preset(input logic [2:0] a);
        case (a)
            REF_GEN_ADDR: preset = PRESET_REF;
            PRED_ADDR:    preset = PRESET_PRED;
            OCD_ADDR:     preset = PRESET_OCD;
            FREQ_ADDR:    preset = PRESET_FREQ;
            PW_ADDR:      preset = PRESET_PW;
            default:      preset = 8'd0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        addr_d      = addr_q;
        en_d        = 1'b0;
        ovf_d       = 1'b0;
        fault_d     = fault_q;
        idx_d       = idx_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        win_d       = win_q;
        trip_d      = trip_q;
        trip_reach  = 1'b0;
        pend_take   = 1'b0;
`ifdef CONF_SOFTSTART_EN
        cur_pw_d    = cur_pw_q;
        ramp_tgt_d  = ramp_tgt_q;
        ramp_cnt_d  = ramp_cnt_q;
`endif

        // Trip window: an edge seen in the wrap cycle starts the new window's count.
        // The count saturates so a fault is only raised on the edge that reaches TRIP_MAX.
        trip_rise = ocd_trip & ~ocd_prev_q;
        win_wrap  = (win_q == WIN_W'(WINDOW_CYC - 1));
        if (win_wrap) begin
            win_d      = '0;
            trip_d     = TRIP_W'(trip_rise);
            trip_reach = trip_rise && (TRIP_MAX == 1);
        end else begin
            win_d = win_q + WIN_W'(1);
            if (trip_rise && (trip_q != TRIP_W'(TRIP_MAX))) begin
                trip_d     = trip_q + TRIP_W'(1);
                trip_reach = (trip_q == TRIP_W'(TRIP_MAX - 1));
            end
        end

        if (fault_clr) begin
            fault_d = 1'b0;
            trip_d  = '0;
        end
        // A trip reaching the limit outranks a simultaneous clear.
        if (trip_reach) begin
            fault_d = 1'b1;
            trip_d  = TRIP_W'(TRIP_MAX);
        end

        uart_ok = uart_rdy && (uart_addr <= ADDR_MAX) &&
                  !(fault_q && (uart_addr == PW_ADDR));

        // Entering FLT always leaves en low, so the override write is never back-to-back.
        if (trip_reach && (state_q != S_INIT)) begin
            state_d = S_FLT;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (en_q) begin
                        if (idx_q == INIT_DONE) begin
                            state_d = fault_d ? S_FLT : S_IDLE;
                        end
                    end else begin
                        en_d   = 1'b1;
                        addr_d = idx_q;
                        data_d = preset(idx_q);
                        idx_d  = idx_q + 3'd1;
                    end
                end
                S_IDLE: begin
                    if (pend_vld_q && !en_q) begin
                        pend_take = 1'b1;
                        // A PW write queued before the fault latched is discarded too.
                        if (!(fault_q && (pend_addr_q == PW_ADDR))) begin
                            en_d    = 1'b1;
                            addr_d  = pend_addr_q;
                            data_d  = pend_data_q;
                            state_d = S_FWD;
`ifdef CONF_SOFTSTART_EN
                            if ((pend_addr_q == PW_ADDR) && (pend_data_q > cur_pw_q)) begin
                                data_d     = cur_pw_q + 8'd1;
                                ramp_tgt_d = pend_data_q;
                                ramp_cnt_d = '0;
                                if (cur_pw_q + 8'd1 != pend_data_q) begin
                                    state_d = S_RAMP;
                                end
                            end
`endif
                        end
                    end
                end
                S_FWD: begin
                    state_d = S_IDLE;
                end
                S_FLT: begin
                    en_d    = 1'b1;
                    addr_d  = PW_ADDR;
                    data_d  = 8'd0;
                    state_d = S_IDLE;
                end
`ifdef CONF_SOFTSTART_EN
                S_RAMP: begin
                    // Ramp steps take priority; other pending writes fill the gaps.
                    if (ramp_cnt_q == RC_W'(RAMP_CYC - 1)) begin
                        if (!en_q) begin
                            en_d       = 1'b1;
                            addr_d     = PW_ADDR;
                            data_d     = cur_pw_q + 8'd1;
                            ramp_cnt_d = '0;
                            if (cur_pw_q + 8'd1 == ramp_tgt_q) begin
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RC_W'(1);
                        if (pend_vld_q && !en_q) begin
                            pend_take = 1'b1;
                            if (pend_addr_q != PW_ADDR) begin
                                en_d   = 1'b1;
                                addr_d = pend_addr_q;
                                data_d = pend_data_q;
                            end else if (pend_data_q > cur_pw_q) begin
                                ramp_tgt_d = pend_data_q;
                            end else begin
                                en_d    = 1'b1;
                                addr_d  = PW_ADDR;
                                data_d  = pend_data_q;
                                state_d = S_FWD;
                            end
                        end
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (pend_take) begin
            pend_vld_d = 1'b0;
        end
        if (uart_ok) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = uart_addr;
            pend_data_d = uart_data;
            ovf_d       = pend_vld_q && !pend_take;
        end

`ifdef CONF_SOFTSTART_EN
        if (en_d && (addr_d == PW_ADDR)) begin
            cur_pw_d = data_d;
        end
        busy_d = (state_d == S_INIT) || (state_d == S_RAMP);
`else
        busy_d = (state_d == S_INIT);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            data_q      <= '0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b1;
            fault_q     <= 1'b0;
            ovf_q       <= 1'b0;
            idx_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            ocd_prev_q  <= 1'b0;
            win_q       <= '0;
            trip_q      <= '0;
`ifdef CONF_SOFTSTART_EN
            cur_pw_q    <= '0;
            ramp_tgt_q  <= '0;
            ramp_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            ovf_q       <= ovf_d;
            idx_q       <= idx_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            ocd_prev_q  <= ocd_trip;
            win_q       <= win_d;
            trip_q      <= trip_d;
`ifdef CONF_SOFTSTART_EN
            cur_pw_q    <= cur_pw_d;
            ramp_tgt_q  <= ramp_tgt_d;
            ramp_cnt_q  <= ramp_cnt_d;
`endif
        end
    end

    assign data  = data_q;
    assign addr  = addr_q;
    assign en    = en_q;
    assign busy  = busy_q;
    assign fault = fault_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_conf_bus_sched.sv
module tb_conf_bus_sched;

    localparam int unsigned W = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] uart_data = '0;
    logic [2:0] uart_addr = '0;
    logic       uart_rdy = 1'b0;
    logic       ocd_trip = 1'b0;
    logic       fault_clr = 1'b0;
    logic [7:0] data;
    logic [2:0] addr;
    logic       en;
    logic       busy;
    logic       fault;
    logic       ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    conf_bus_sched #(
        .WINDOW_CYC(W),
        .TRIP_MAX(4)
`ifdef CONF_SOFTSTART_EN
        ,
        .RAMP_CYC(4)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_data(uart_data),
        .uart_addr(uart_addr),
        .uart_rdy(uart_rdy),
        .ocd_trip(ocd_trip),
        .fault_clr(fault_clr),
        .data(data),
        .addr(addr),
        .en(en),
        .busy(busy),
        .fault(fault),
        .ovf(ovf)
    );

    typedef struct {
        logic       rdy;
        logic [2:0] ua;
        logic [7:0] ud;
        logic       en;
        logic [2:0] a;
        logic [7:0] d;
        logic       busy;
        logic       ovf;
    } vec_t;

    vec_t tbl[22];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_wr(input string name, input int a, input int d);
        chk({name, ".en"}, en, 1);
        chk({name, ".addr"}, addr, a);
        chk({name, ".data"}, data, d);
    endtask

    task automatic send(input logic [2:0] a, input logic [7:0] d);
        uart_rdy  = 1'b1;
        uart_addr = a;
        uart_data = d;
        tick();
        uart_rdy  = 1'b0;
    endtask

    task automatic pulse();
        ocd_trip = 1'b1;
        tick();
        ocd_trip = 1'b0;
        tick();
    endtask

    task automatic align(input int pos);
        for (int i = 0; (i < int'(W)) && ((cyc % int'(W)) != pos); i++) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pw;
        //          rdy ua  ud   en a  d    busy ovf
        tbl[0]  = '{0, 0, 0,   1, 0, 127, 1, 0};
        tbl[1]  = '{0, 0, 0,   0, 0, 127, 1, 0};
        tbl[2]  = '{1, 1, 5,   1, 1, 30,  1, 0};
        tbl[3]  = '{0, 0, 0,   0, 1, 30,  1, 0};
        tbl[4]  = '{0, 0, 0,   1, 2, 87,  1, 0};
        tbl[5]  = '{1, 1, 9,   0, 2, 87,  1, 1};
        tbl[6]  = '{0, 0, 0,   1, 3, 10,  1, 0};
        tbl[7]  = '{0, 0, 0,   0, 3, 10,  1, 0};
        tbl[8]  = '{0, 0, 0,   1, 4, 1,   1, 0};
        tbl[9]  = '{0, 0, 0,   0, 4, 1,   0, 0};
        tbl[10] = '{0, 0, 0,   1, 1, 9,   0, 0};
        tbl[11] = '{0, 0, 0,   0, 1, 9,   0, 0};
        tbl[12] = '{1, 3, 20,  0, 1, 9,   0, 0};
        tbl[13] = '{0, 0, 0,   1, 3, 20,  0, 0};
        tbl[14] = '{0, 0, 0,   0, 3, 20,  0, 0};
        tbl[15] = '{1, 5, 77,  0, 3, 20,  0, 0};
        tbl[16] = '{0, 0, 0,   0, 3, 20,  0, 0};
        tbl[17] = '{1, 0, 11,  0, 3, 20,  0, 0};
        tbl[18] = '{1, 2, 22,  1, 0, 11,  0, 0};
        tbl[19] = '{0, 0, 0,   0, 0, 11,  0, 0};
        tbl[20] = '{0, 0, 0,   1, 2, 22,  0, 0};
        tbl[21] = '{0, 0, 0,   0, 2, 22,  0, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.en", en, 0);
        chk("rst.addr", addr, 0);
        chk("rst.data", data, 0);
        chk("rst.busy", busy, 1);
        chk("rst.fault", fault, 0);
        chk("rst.ovf", ovf, 0);
        rst_n = 1'b1;
        cyc = 0;

        // Preset load, UART overwrite during INIT, forwarding, dropped address
        for (int i = 0; i < 22; i++) begin
            uart_rdy  = tbl[i].rdy;
            uart_addr = tbl[i].ua;
            uart_data = tbl[i].ud;
            tick();
            uart_rdy = 1'b0;
            chk($sformatf("vec%0d.en", i), en, int'(tbl[i].en));
            if (tbl[i].en) begin
                chk($sformatf("vec%0d.addr", i), addr, int'(tbl[i].a));
                chk($sformatf("vec%0d.data", i), data, int'(tbl[i].d));
            end
            chk($sformatf("vec%0d.busy", i), busy, int'(tbl[i].busy));
            chk($sformatf("vec%0d.ovf", i), ovf, int'(tbl[i].ovf));
            chk($sformatf("vec%0d.fault", i), fault, 0);
        end

        // 3 edges, then one edge in the wrap cycle: new window holds 1, no fault
        align(50);
        repeat (3) pulse();
        align(63);
        ocd_trip = 1'b1;
        tick();
        ocd_trip = 1'b0;
        tick();
        chk("wrap.nofault", fault, 0);
        repeat (2) pulse();
        chk("wrap.cnt3.nofault", fault, 0);
        // 4th edge of the new window latches the fault
        ocd_trip = 1'b1;
        tick();
        ocd_trip = 1'b0;
        chk("trip.fault", fault, 1);
        chk("trip.en_gap", en, 0);
        tick();
        chk_wr("trip.pw0", 4, 0);
        tick();
        chk("trip.after.en", en, 0);
        chk("trip.after.fault", fault, 1);

        // PW writes dropped under fault, other addresses still forwarded
        send(3'd4, 8'd50);
        chk("drop.pw.c1", en, 0);
        tick();
        chk("drop.pw.c2", en, 0);
        tick();
        chk("drop.pw.c3", en, 0);
        send(3'd1, 8'd33);
        chk("pass.a1.c1", en, 0);
        tick();
        chk_wr("pass.a1", 1, 33);
        tick();

        // Clear fault, PW write goes through again
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr.fault", fault, 0);
        send(3'd4, 8'd50);
        tick();
`ifdef CONF_SOFTSTART_EN
        exp_pw = 1;
`else
        exp_pw = 50;
`endif
        chk_wr("clr.pw50", 4, exp_pw);
        tick();

        // fault_clr in the same cycle as the limit-reaching edge: fault wins
        align(2);
        repeat (3) pulse();
        ocd_trip  = 1'b1;
        fault_clr = 1'b1;
        tick();
        ocd_trip  = 1'b0;
        fault_clr = 1'b0;
        chk("race.fault", fault, 1);
        tick();
        chk_wr("race.pw0", 4, 0);
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("race.clr", fault, 0);
        // Clear restarted the count: 3 edges safe, 4th faults
        repeat (3) pulse();
        chk("recount.3", fault, 0);
        ocd_trip = 1'b1;
        tick();
        ocd_trip = 1'b0;
        chk("recount.4", fault, 1);
        tick();
        chk_wr("recount.pw0", 4, 0);
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

        // Reset in the middle of the preset load
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc = 0;
        repeat (3) tick();
        chk_wr("mid.pre", 1, 30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.rst.en", en, 0);
        chk("mid.rst.busy", busy, 1);
        chk("mid.rst.addr", addr, 0);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        tick();
        chk_wr("mid.restart", 0, 127);
        repeat (8) tick();
        chk_wr("mid.last", 4, 1);
        tick();
        chk("mid.busy", busy, 0);

`ifdef CONF_SOFTSTART_EN
        // PW 1 -> 5 ramps one step every 4 cycles
        send(3'd4, 8'd5);
        chk("ramp.c0", en, 0);
        tick();
        chk_wr("ramp.s2", 4, 2);
        chk("ramp.busy", busy, 1);
        for (int s = 3; s <= 5; s++) begin
            for (int g = 0; g < 3; g++) begin
                tick();
                chk($sformatf("ramp.gap%0d_%0d", s, g), en, 0);
            end
            tick();
            chk_wr($sformatf("ramp.s%0d", s), 4, s);
        end
        chk("ramp.done.busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
